// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// master drives the stream, slave is the loader.
interface imem_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, in_valid, in_byte,
    input  in_ready, mem_we, mem_addr,
    input  mem_wdata, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_byte,
    output in_ready, mem_we, mem_addr,
    output mem_wdata, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-serial program loader: LEN_LO, LEN_HI, then 4*N little-endian
// bytes written as words to consecutive instruction-memory addresses.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN0  = 3'd1;
  localparam logic [2:0] LEN1  = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [31:0]   wbuf_q, wbuf_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rdy_q, rdy_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          xfer;
  logic          last;
  logic [15:0]   len_full;

  assign xfer     = bus.in_valid & rdy_q;
  assign len_full = {bus.in_byte, len_q[7:0]};
  assign last     = ({{(16-AW){1'b0}}, widx_q} + 16'd1) == len_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    wbuf_d  = wbuf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d = LEN0;
          widx_d  = '0;
          bidx_d  = '0;
        end
      end
      LEN0: begin
        if (xfer) begin
          len_d[7:0] = bus.in_byte;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          len_d[15:8] = bus.in_byte;
          if (len_full == 16'd0)
            state_d = DONE;
          else if (len_full > 16'(DEPTH))
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          wbuf_d[8*bidx_q +: 8] = bus.in_byte;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = WRITE;
            addr_d  = 32'({widx_q, 2'b00});
            wdata_d = {bus.in_byte, wbuf_q[23:0]};
          end
        end
      end
      WRITE: begin
        // Index is left at the last word so it never passes DEPTH-1
        if (last) begin
          state_d = DONE;
        end else begin
          widx_d  = widx_q + 1'b1;
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy_d  = (state_d == LEN0) || (state_d == LEN1) ||
                  (state_d == DATA);
  assign we_d   = (state_d == WRITE);
  assign busy_d = rdy_d | we_d;
  assign done_d = (state_d == DONE);
  assign err_d  = (state_d == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      wbuf_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      wbuf_q  <= wbuf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, normal, empty, oversize,
// throttled, mid-word reset and full-depth images.
module tb_imem_loader;
  logic clk;
  logic rst_n;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int nxfer = 0;
  logic [31:0] wq_a [$];
  logic [31:0] wq_d [$];
  logic [7:0]  img [$];

  always @(posedge clk)
    if (bus.in_valid && bus.in_ready) nxfer++;

  always @(negedge clk)
    if (bus.mem_we) begin
      wq_a.push_back(bus.mem_addr);
      wq_d.push_back(bus.mem_wdata);
    end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clear();
    wq_a.delete();
    wq_d.delete();
    nxfer = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("rdy_tmo", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_img(input int maxgap);
    foreach (img[i])
      send_byte(img[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_two(input string p);
    chk({p, "_nwr"}, wq_a.size(), 32'd2);
    if (wq_a.size() >= 2) begin
      chk({p, "_a0"}, wq_a[0], 32'h0000_0000);
      chk({p, "_d0"}, wq_d[0], 32'h0000_00B3);
      chk({p, "_a1"}, wq_a[1], 32'h0000_0004);
      chk({p, "_d1"}, wq_d[1], 32'h0000_0233);
    end
    chk({p, "_done"}, 32'(bus.done), 32'd1);
    chk({p, "_busy"}, 32'(bus.busy), 32'd0);
    chk({p, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({bus.in_ready, bus.mem_we, bus.busy,
                        bus.done, bus.err}), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_xfer", nxfer, 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Two-word image, continuous stream
    img = '{8'h02, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00,
            8'h33, 8'h02, 8'h00, 8'h00};
    clear();
    pulse_start();
    chk("t2_busy", 32'(bus.busy), 32'd1);
    send_img(0);
    bus.in_valid = 1'b0;
    wait_idle();
    check_two("t2");
    chk("t2_xfer", nxfer, 32'd10);

    // Zero length
    clear();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    bus.in_valid = 1'b0;
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_nwr", wq_a.size(), 32'd0);

    // Oversize, then recovery
    clear();
    pulse_start();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    bus.in_valid = 1'b0;
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_done", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_nwr", wq_a.size(), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    clear();
    pulse_start();
    chk("t4_errclr", 32'(bus.err), 32'd0);
    send_img(0);
    bus.in_valid = 1'b0;
    wait_idle();
    check_two("t4r");

    // Throttled stream, start pulse while busy, extra bytes held
    clear();
    pulse_start();
    fork
      send_img(3);
      begin
        repeat (6) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    bus.in_byte = 8'hEE;
    repeat (8) @(negedge clk);
    chk("t5_xfer", nxfer, 32'd10);
    bus.in_valid = 1'b0;
    check_two("t5");

    // Reset after two data bytes
    clear();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hB3, 0);
    send_byte(8'h00, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_rdy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_nwr", wq_a.size(), 32'd0);
    clear();
    pulse_start();
    send_img(0);
    bus.in_valid = 1'b0;
    wait_idle();
    check_two("t6");

    // Full depth: word i = {~i, 22, 11, i}
    img.delete();
    img.push_back(8'h40);
    img.push_back(8'h00);
    for (int i = 0; i < 64; i++) begin
      img.push_back(8'(i));
      img.push_back(8'h11);
      img.push_back(8'h22);
      img.push_back(~8'(i));
    end
    clear();
    pulse_start();
    send_img(0);
    bus.in_valid = 1'b0;
    wait_idle();
    chk("t7_nwr", wq_a.size(), 32'd64);
    if (wq_a.size() == 64) begin
      chk("t7_d0", wq_d[0], 32'hFF22_1100);
      chk("t7_a63", wq_a[63], 32'h0000_00FC);
      chk("t7_d63", wq_d[63], 32'hC022_113F);
    end
    chk("t7_done", 32'(bus.done), 32'd1);
    chk("t7_xfer", nxfer, 32'd258);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
